shot_resolver: RTL and testbench
================================

// Module: shot_resolver
// PURPOSE
//   Upstream stage of the 10x10 grid-cell array. Accepts fire requests
//   (row, col) over a valid/ready handshake and rejects repeat or off-grid
//   shots. For each accepted shot it drives a one-cycle shot pulse into the
//   addressed cell, tracks hits per ship, and on a sink drives a one-cycle
//   ship_sunk pulse covering that ship and its 8-neighbour halo.
//   Also drives the array's is_ship vector, decoded from the ship table.
// PARAMETERS
//   GRID_N     10  grid edge length; cell index = row*GRID_N + col
//   NUM_SHIPS  5   ship table entries
// PORTS
//   clk           in   1               rising-edge clock
//   reset         in   1               synchronous, active-high
//   ship_cfg      in   12*NUM_SHIPS    entry k = [12k+11]=horiz, [12k+10:12k+8]=len,
//                                      [12k+7:12k+4]=row, [12k+3:12k]=col
//   fire_valid    in   1               fire request present
//   fire_ready    out  1               resolver can accept a request
//   fire_row      in   4               target row
//   fire_col      in   4               target col
//   is_ship       out  GRID_N*GRID_N   combinational occupancy decode of ship_cfg
//   shot          out  GRID_N*GRID_N   one-hot, one-cycle shot pulse
//   ship_sunk     out  GRID_N*GRID_N   one-cycle pulse: sunk ship cells plus halo
//   result_valid  out  1               one-cycle result strobe
//   result_code   out  2               00 miss, 01 hit, 10 sunk, 11 rejected
//   result_ship   out  3               ship index for hit/sunk, else 0
//   all_sunk      out  1               sticky game-over flag
// BEHAVIOUR
//   Clock and reset
//   - One clock domain.
//   - Reset is synchronous and active-high; it is sampled on the clk edge.
//   - Reset values: FSM=IDLE; fired mask, hit counters, shot, ship_sunk,
//     result_* and all_sunk all 0.
//   - fire_ready is forced to 0 while reset is high.
//   - Reset mid-operation aborts immediately. No pulse from the aborted
//     request is emitted after the reset edge.
//   Ship table
//   - ship_cfg is static outside reset.
//   - A ship covers len cells from (row, col), extending along +col if
//     horiz=1, else along +row.
//   - len=0 marks an unused entry; it counts as sunk.
//   - Off-grid segments are ignored.
//   - sink threshold = number of on-grid cells of the ship.
//   - On overlapping cells, the lowest ship index owns the cell.
//   FSM: IDLE -> EVAL -> (IDLE | SINK -> IDLE)
//   - IDLE: fire_ready = !all_sunk. On fire_valid && fire_ready, latch
//     row/col and go to EVAL.
//   - EVAL (accept edge +1 cycle):
//     - row >= GRID_N, col >= GRID_N, or cell already fired:
//       result_valid=1, code=11, no shot pulse, go to IDLE.
//     - Otherwise: shot[idx]=1, set fired[idx].
//     - Unowned cell: code=00 this cycle, go to IDLE.
//     - Owned by ship k: hit[k]++. If the new count < threshold, code=01,
//       ship=k, go to IDLE. Else go to SINK with no result this cycle.
//   - SINK (accept edge +2 cycles):
//     - ship_sunk = cells of ship k OR'd with all their on-grid 8-neighbours.
//     - Halo is clipped at grid edges; no wrap from col GRID_N-1 to col 0.
//     - result_valid=1, code=10, ship=k.
//     - Mark k sunk; all_sunk updates on the same edge if every ship is sunk.
//     - Go to IDLE.
//   - shot and ship_sunk are never asserted in the same cycle. A hit cell
//     therefore takes one cycle in its hit state before turning sunk.
//   Throughput and counters
//   - Minimum spacing between accepts: 2 cycles (hit/miss/reject), 3 cycles (sink).
//   - Hit counters are 3 bits and saturate at the threshold; a sunk ship
//     cannot be re-hit because its cells are already fired.
//   all_sunk
//   - Sticky until reset.
//   - While set, fire_ready=0 and all requests stall.
// TESTING
//   1 Single shot to empty cell:
//     ship0 horiz len2 at (0,0); fire (5,5) -> shot[55] pulse 1 cycle,
//     code 00, is_ship[0]=is_ship[1]=1.
//   2 Sink with edge clip:
//     fire (0,0) -> code 01 ship 0; fire (0,1) -> code 10 ship 0.
//     ship_sunk = {0,1,2,10,11,12} exactly, asserted 1 cycle after shot[1].
//   3 Repeat shot:
//     fire (5,5) twice -> 2nd gives code 11, shot stays 0.
//     Off-grid fire (10,3) -> code 11.
//   4 Game over:
//     all 5 ships sunk -> all_sunk=1 and fire_ready=0.
//     Holding fire_valid=1 for 10 cycles -> no further pulses.
//   5 Reset mid-flight:
//     assert reset in the EVAL cycle of a sinking shot -> no ship_sunk pulse;
//     all outputs 0 next cycle; fire_ready=1 the cycle after reset drops.
//   6 Vertical ship at (8,9) len3:
//     threshold=2 (row 10 off-grid); hits on (8,9),(9,9) -> code 10;
//     halo excludes col 0 of any row.

Source files
------------

// File: rtl/shot_resolver.sv
// Fire-request resolver for the 10x10 grid-cell array: decodes the ship table,
// classifies each shot as miss/hit/sunk/rejected and drives shot and sink pulses.
module shot_resolver #(
  parameter int GRID_N    = 10,
  parameter int NUM_SHIPS = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [12*NUM_SHIPS-1:0]     ship_cfg,
  input  logic                        fire_valid,
  output logic                        fire_ready,
  input  logic [3:0]                  fire_row,
  input  logic [3:0]                  fire_col,
  output logic [GRID_N*GRID_N-1:0]    is_ship,
  output logic [GRID_N*GRID_N-1:0]    shot,
  output logic [GRID_N*GRID_N-1:0]    ship_sunk,
  output logic                        result_valid,
  output logic [1:0]                  result_code,
  output logic [2:0]                  result_ship,
  output logic                        all_sunk
);
  localparam int CELLS = GRID_N * GRID_N;
  localparam int IDX_W = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, SINK = 2'd2} state_t;
  state_t state, state_nxt;

  function automatic logic [2:0] sat_inc(input logic [2:0] cnt, input logic [2:0] lim);
    return (cnt >= lim) ? lim : cnt + 3'd1;
  endfunction

  logic [CELLS-1:0]     ship_mask [NUM_SHIPS];
  logic [2:0]           thresh    [NUM_SHIPS];
  logic [CELLS-1:0]     owned;
  logic [2:0]           owner     [CELLS];
  logic [3:0]           row_p0, col_p0;
  logic [2:0]           ship_p1;
  logic [CELLS-1:0]     fired;
  logic [2:0]           hit       [NUM_SHIPS];
  logic [NUM_SHIPS-1:0] sunk_flag, done_nxt;
  logic                 tgt_off, tgt_reject, tgt_owned, tgt_sink;
  logic [IDX_W-1:0]     tgt_idx;
  logic [2:0]           tgt_ship, tgt_hit_nxt;
  logic [CELLS-1:0]     sink_mask, halo;

  // Ship table decode; off-grid segment cells drop out of both mask and threshold
  always_comb begin
    for (int k = 0; k < NUM_SHIPS; k++) begin
      ship_mask[k] = '0;
      thresh[k]    = '0;
      for (int i = 0; i < 7; i++) begin
        int r, c;
        r = int'(ship_cfg[12*k+4 +: 4]) + (ship_cfg[12*k+11] ? 0 : i);
        c = int'(ship_cfg[12*k +: 4])   + (ship_cfg[12*k+11] ? i : 0);
        if (i < int'(ship_cfg[12*k+8 +: 3]) && r < GRID_N && c < GRID_N) begin
          ship_mask[k][IDX_W'(r*GRID_N + c)] = 1'b1;
          thresh[k] = thresh[k] + 3'd1;
        end
      end
    end
  end

  // Descending scan so the lowest ship index wins an overlapped cell
  always_comb begin
    for (int j = 0; j < CELLS; j++) begin
      owned[j] = 1'b0;
      owner[j] = '0;
      for (int k = NUM_SHIPS-1; k >= 0; k--) begin
        if (ship_mask[k][j]) begin
          owned[j] = 1'b1;
          owner[j] = 3'(k);
        end
      end
    end
  end

  assign is_ship = owned;

  // EVAL stage: classify the latched request (_p0)
  always_comb begin
    tgt_off     = (int'(row_p0) >= GRID_N) || (int'(col_p0) >= GRID_N);
    tgt_idx     = IDX_W'(int'(row_p0) * GRID_N + int'(col_p0));
    tgt_reject  = tgt_off || fired[tgt_idx];
    tgt_owned   = !tgt_off && owned[tgt_idx];
    tgt_ship    = tgt_off ? 3'd0 : owner[tgt_idx];
    tgt_hit_nxt = sat_inc(hit[tgt_ship], thresh[tgt_ship]);
    tgt_sink    = !tgt_reject && tgt_owned && (tgt_hit_nxt >= thresh[tgt_ship]);
  end

  // SINK stage: halo of the sunk ship (_p1), clipped at every grid edge
  assign sink_mask = ship_mask[ship_p1];

  always_comb begin
    halo = '0;
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int nr, nc;
            nr = r + dr;
            nc = c + dc;
            if (nr >= 0 && nr < GRID_N && nc >= 0 && nc < GRID_N &&
                sink_mask[IDX_W'(nr*GRID_N + nc)])
              halo[IDX_W'(r*GRID_N + c)] = 1'b1;
          end
        end
      end
    end
  end

  // Unused and fully off-grid entries count as already sunk
  always_comb begin
    for (int k = 0; k < NUM_SHIPS; k++)
      done_nxt[k] = sunk_flag[k] || (thresh[k] == 3'd0) || (ship_p1 == 3'(k));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire_valid && fire_ready) state_nxt = EVAL;
      EVAL:    state_nxt = tgt_sink ? SINK : IDLE;
      SINK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fire_ready   = (state == IDLE) && !all_sunk && !reset;
    shot         = '0;
    ship_sunk    = '0;
    result_valid = 1'b0;
    result_code  = 2'b00;
    result_ship  = 3'd0;
    case (state)
      EVAL: begin
        if (tgt_reject) begin
          result_valid = 1'b1;
          result_code  = 2'b11;
        end else begin
          shot[tgt_idx] = 1'b1;
          if (!tgt_owned) begin
            result_valid = 1'b1;
            result_code  = 2'b00;
          end else if (!tgt_sink) begin
            result_valid = 1'b1;
            result_code  = 2'b01;
            result_ship  = tgt_ship;
          end
        end
      end
      SINK: begin
        ship_sunk    = halo;
        result_valid = 1'b1;
        result_code  = 2'b10;
        result_ship  = ship_p1;
      end
      default: ;
    endcase
  end

  // Request and ship-index latches carry data only
  always_ff @(posedge clk) begin
    if (state == IDLE && fire_valid && fire_ready) begin
      row_p0 <= fire_row;
      col_p0 <= fire_col;
    end
    if (state == EVAL) ship_p1 <= tgt_ship;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fired     <= '0;
      sunk_flag <= '0;
      all_sunk  <= 1'b0;
      for (int k = 0; k < NUM_SHIPS; k++) hit[k] <= '0;
    end else begin
      if (state == EVAL && !tgt_reject) begin
        fired[tgt_idx] <= 1'b1;
        if (tgt_owned) hit[tgt_ship] <= tgt_hit_nxt;
      end
      if (state == SINK) begin
        sunk_flag[ship_p1] <= 1'b1;
        all_sunk           <= all_sunk | (&done_nxt);
      end
    end
  end

endmodule

// File: tb/tb_shot_resolver.sv
// Directed bench for shot_resolver with a result/shot scoreboard checked by a negedge monitor.
module tb_shot_resolver;
  localparam int GRID_N    = 10;
  localparam int NUM_SHIPS = 5;
  localparam int CELLS     = GRID_N * GRID_N;

  typedef struct {
    logic [1:0]       code;
    logic [2:0]       ship;
    logic [CELLS-1:0] sunk;
  } res_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [12*NUM_SHIPS-1:0] ship_cfg;
  logic                    fire_valid, fire_ready;
  logic [3:0]              fire_row, fire_col;
  logic [CELLS-1:0]        is_ship, shot, ship_sunk;
  logic                    result_valid;
  logic [1:0]              result_code;
  logic [2:0]              result_ship;
  logic                    all_sunk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_shot_cyc = 0;
  res_t exp_q[$];
  logic [CELLS-1:0] shot_q[$];
  res_t mon_e;
  logic [CELLS-1:0] mon_s;
  logic [CELLS-1:0] mask0, mask1, mask2, ship_exp;

  shot_resolver #(.GRID_N(GRID_N), .NUM_SHIPS(NUM_SHIPS)) dut (
    .clk(clk), .reset(reset), .ship_cfg(ship_cfg),
    .fire_valid(fire_valid), .fire_ready(fire_ready),
    .fire_row(fire_row), .fire_col(fire_col),
    .is_ship(is_ship), .shot(shot), .ship_sunk(ship_sunk),
    .result_valid(result_valid), .result_code(result_code),
    .result_ship(result_ship), .all_sunk(all_sunk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CELLS-1:0] b(input int i);
    logic [CELLS-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic expect_res(input logic [1:0] code, input logic [2:0] ship, input logic [CELLS-1:0] sunk);
    res_t e;
    e.code = code;
    e.ship = ship;
    e.sunk = sunk;
    exp_q.push_back(e);
  endtask

  task automatic expect_shot(input int idx);
    shot_q.push_back(b(idx));
  endtask

  task automatic fire(input int r, input int c);
    int w;
    w = 0;
    @(negedge clk);
    while (!fire_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("fire_ready_wait", fire_ready, 1);
    fire_row   = 4'(r);
    fire_col   = 4'(c);
    fire_valid = 1'b1;
    @(posedge clk);
    #1 fire_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && (exp_q.size() != 0 || shot_q.size() != 0); i++) @(negedge clk);
    chk("drain", exp_q.size() + shot_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (shot != '0) begin
        if (shot_q.size() == 0) chk("shot_unexpected", shot, 0);
        else begin
          mon_s = shot_q.pop_front();
          chk("shot_vec", shot, mon_s);
        end
        if (ship_sunk != '0) chk("shot_with_sunk", ship_sunk, 0);
        last_shot_cyc = cyc;
      end
      if (result_valid) begin
        if (exp_q.size() == 0) chk("result_unexpected", result_valid, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("result_code", result_code, mon_e.code);
          chk("result_ship", result_ship, mon_e.ship);
          chk("sunk_mask", ship_sunk, mon_e.sunk);
          if (mon_e.code == 2'b10) chk("sink_delay", cyc - last_shot_cyc, 1);
        end
      end else if (ship_sunk != '0) chk("sunk_stray", ship_sunk, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    mask0    = b(0) | b(1) | b(2) | b(10) | b(11) | b(12);
    mask1    = b(78) | b(79) | b(88) | b(89) | b(98) | b(99);
    mask2    = b(46) | b(47) | b(48) | b(56) | b(57) | b(58) | b(66) | b(67) | b(68);
    ship_exp = b(0) | b(1) | b(57) | b(89) | b(99);
    reset      = 1'b1;
    fire_valid = 1'b0;
    fire_row   = '0;
    fire_col   = '0;
    ship_cfg   = {12'h000, 12'h000, {1'b1, 3'd1, 4'd5, 4'd7},
                  {1'b0, 3'd3, 4'd8, 4'd9}, {1'b1, 3'd2, 4'd0, 4'd0}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", fire_ready, 0);
    chk("rst_shot", shot, 0);
    chk("rst_sunk", ship_sunk, 0);
    chk("rst_rvalid", result_valid, 0);
    chk("rst_code", result_code, 0);
    chk("rst_all_sunk", all_sunk, 0);
    chk("is_ship", is_ship, ship_exp);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", fire_ready, 1);

    expect_shot(55); expect_res(2'b00, 3'd0, '0); fire(5, 5); drain();
    expect_shot(0);  expect_res(2'b01, 3'd0, '0); fire(0, 0); drain();
    expect_shot(1);  expect_res(2'b10, 3'd0, mask0); fire(0, 1); drain();
    expect_res(2'b11, 3'd0, '0); fire(5, 5); drain();
    expect_res(2'b11, 3'd0, '0); fire(10, 3); drain();
    expect_shot(89); expect_res(2'b01, 3'd1, '0); fire(8, 9); drain();
    expect_shot(99); expect_res(2'b10, 3'd1, mask1); fire(9, 9); drain();
    chk("all_sunk_early", all_sunk, 0);

    expect_shot(57); expect_res(2'b10, 3'd2, mask2); fire(5, 7); drain();
    repeat (2) @(negedge clk);
    chk("all_sunk_set", all_sunk, 1);
    chk("ready_game_over", fire_ready, 0);
    fire_row   = 4'd2;
    fire_col   = 4'd2;
    fire_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_ready", fire_ready, 0);
    end
    fire_valid = 1'b0;
    chk("all_sunk_sticky", all_sunk, 1);

    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_post_rst", fire_ready, 1);
    chk("all_sunk_cleared", all_sunk, 0);
    expect_shot(0); expect_res(2'b01, 3'd0, '0); fire(0, 0); drain();
    @(negedge clk);
    chk("ready_mid", fire_ready, 1);
    fire_row   = 4'd0;
    fire_col   = 4'd1;
    fire_valid = 1'b1;
    @(posedge clk);
    #1 fire_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_in_rst", fire_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_shot", shot, 0);
    chk("abort_sunk", ship_sunk, 0);
    chk("abort_rvalid", result_valid, 0);
    chk("abort_code", result_code, 0);
    chk("abort_all_sunk", all_sunk, 0);
    chk("abort_ready", fire_ready, 1);
    repeat (3) @(negedge clk);
    expect_shot(0); expect_res(2'b01, 3'd0, '0); fire(0, 0); drain();
    expect_shot(1); expect_res(2'b10, 3'd0, mask0); fire(0, 1); drain();
    repeat (2) @(negedge clk);
    chk("queues_empty", exp_q.size() + shot_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
